// File: rtl/fractional_decimator.sv
// fractional_decimator: 2/3 polyphase resampler (x2 interpolate, N_TAP lowpass, /3 decimate) with a programmable bank.
// Define FRAC_DEC_ROUND_EN for round-half-up output; otherwise the output truncates toward -inf.
module fractional_decimator #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 15,
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_FRAC  = 18,
  parameter int N_TAP       = 72
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         bypass,
  input  logic                         coeff_wr_en,
  input  logic [COEFF_WIDTH*N_TAP-1:0] coeff_data_in,
  output logic [COEFF_WIDTH*N_TAP-1:0] coeff_data_out,
  input  logic [DATA_WIDTH-1:0]        filter_in,
  output logic [DATA_WIDTH-1:0]        filter_out,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         valid_out
);
  localparam int PH = N_TAP / 2;
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = PW + 6;
  localparam int BW = COEFF_WIDTH * N_TAP;
  localparam int LW = DATA_WIDTH * PH;
  localparam int SH = DATA_FRAC + COEFF_FRAC - DATA_FRAC;
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  // Triangular lowpass scaled so each phase sums to exactly 2.0; the rounding
  // remainder lands on the two centre taps, keeping the table symmetric.
  function automatic logic [BW-1:0] default_bank();
    int psum, scale, tv;
    logic [BW-1:0] b;
    psum = 0;
    for (int k = 0; k < N_TAP; k += 2) psum += (k + 1 < N_TAP - k) ? k + 1 : N_TAP - k;
    scale = (1 << (COEFF_FRAC + 1)) / psum;
    b = '0;
    for (int k = 0; k < N_TAP; k++) begin
      tv = scale * ((k + 1 < N_TAP - k) ? k + 1 : N_TAP - k);
      if (k == PH - 1 || k == PH) tv += (1 << (COEFF_FRAC + 1)) - scale * psum;
      b[k*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(tv);
    end
    return b;
  endfunction
  localparam logic [BW-1:0] DEF_BANK = default_bank();
  logic [BW-1:0]         bank_q, bank_d;
  logic [LW-1:0]         dl_q, dl_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vout_q, vout_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                  ph, emit, hi, lo;
  logic signed [AW-1:0]  acc, res;
  logic signed [PW-1:0]  prod [PH];
  assign ph = cnt_q[0];
  assign dl_d = valid_in ? {dl_q[LW-DATA_WIDTH-1:0], filter_in} : dl_q;
  for (genvar g = 0; g < PH; g++) begin : g_tap
    assign prod[g] = PW'($signed(bank_q[(2*g+ph)*COEFF_WIDTH +: COEFF_WIDTH]))
                   * PW'($signed(dl_d[g*DATA_WIDTH +: DATA_WIDTH]));
  end
  always_comb begin
    acc = '0;
    for (int i = 0; i < PH; i++) acc = acc + AW'(prod[i]);
`ifdef FRAC_DEC_ROUND_EN
    res = (acc + (AW'(1) <<< (SH - 1))) >>> SH;
`else
    res = acc >>> SH;
`endif
    hi = res > MAXV;
    lo = res < MINV;
    emit = valid_in & ~bypass & (cnt_q != 2'd2);
    cnt_d = (bypass || (valid_in && cnt_q == 2'd2)) ? 2'd0 : valid_in ? cnt_q + 2'd1 : cnt_q;
    out_d = (valid_in && bypass) ? filter_in
          : !emit ? out_q
          : hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
          : lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
          : res[DATA_WIDTH-1:0];
    vout_d = valid_in & (bypass | (cnt_q != 2'd2));
    ovf_d = emit & hi;
    unf_d = emit & lo;
    bank_d = coeff_wr_en ? coeff_data_in : bank_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= DEF_BANK;
      dl_q   <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      vout_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      dl_q   <= dl_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      vout_q <= vout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end
  assign coeff_data_out = bank_q;
  assign filter_out     = out_q;
  assign valid_out      = vout_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
endmodule

// File: tb/tb_fractional_decimator.sv
// tb_fractional_decimator: randomized stimulus against a sample-history reference model of the 2/3 resampler.
module tb_fractional_decimator;
  localparam int CW = 20;
  localparam int NT = 72;
  localparam int PH = 36;
  logic clk = 0, rst_n = 1, valid_in = 0, bypass = 0, coeff_wr_en = 0;
  logic [CW*NT-1:0] coeff_data_in = '0, coeff_data_out;
  logic [15:0] filter_in = '0, filter_out;
  logic overflow, underflow, valid_out;
  int n_checks = 0, n_fail = 0;
  longint mh[NT], nb[NT];
  int hist[PH];
  int mcnt = 0;
  logic exp_v = 0, exp_o = 0, exp_u = 0;
  logic [15:0] exp_y = '0;

  always #5 clk = ~clk;

  fractional_decimator dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .bypass(bypass), .coeff_wr_en(coeff_wr_en),
    .coeff_data_in(coeff_data_in), .coeff_data_out(coeff_data_out), .filter_in(filter_in),
    .filter_out(filter_out), .overflow(overflow), .underflow(underflow), .valid_out(valid_out)
  );

  task automatic model_clear();
    for (int i = 0; i < PH; i++) hist[i] = 0;
    mcnt = 0;
    exp_y = '0;
    exp_v = 0;
    exp_o = 0;
    exp_u = 0;
  endtask

  // One clock: apply inputs, advance the reference model, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic b, input logic wr);
    longint acc, r;
    valid_in = v;
    filter_in = d;
    bypass = b;
    coeff_wr_en = wr;
    if (wr) for (int k = 0; k < NT; k++) coeff_data_in[k*CW +: CW] = CW'(nb[k]);
    @(posedge clk);
    exp_v = v && (b || mcnt != 2);
    exp_o = 0;
    exp_u = 0;
    if (v) begin
      for (int i = PH - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'($signed(d));
    end
    if (b) begin
      if (v) exp_y = d;
      mcnt = 0;
    end else if (v) begin
      if (mcnt < 2) begin
        acc = 0;
        for (int i = 0; i < PH; i++) acc += mh[2*i+mcnt] * hist[i];
`ifdef FRAC_DEC_ROUND_EN
        acc += 64'sd1 << 17;
`endif
        r = acc >>> 18;
        exp_o = r > 32767;
        exp_u = r < -32768;
        exp_y = exp_o ? 16'h7fff : exp_u ? 16'h8000 : r[15:0];
      end
      mcnt = (mcnt + 1) % 3;
    end
    if (wr) mh = nb;
    #1;
  endtask

  task automatic rand_bank(input int bits);
    for (int k = 0; k < NT; k++)
      nb[k] = longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) << (bits - 1));
  endtask

  task automatic test_reset();
    longint se, so;
    logic sym;
    #2 rst_n = 0;
    #10;
    n_checks++;
    if ({valid_out, overflow, underflow} !== 3'b000 || filter_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b o=%b u=%b y=%h, want 0 0 0 0000", valid_out, overflow, underflow, filter_out);
    end
    se = 0; so = 0; sym = 1;
    for (int k = 0; k < NT; k++) begin
      if (k % 2 == 0) se += longint'($signed(coeff_data_out[k*CW +: CW]));
      else so += longint'($signed(coeff_data_out[k*CW +: CW]));
      if (coeff_data_out[k*CW +: CW] !== coeff_data_out[(NT-1-k)*CW +: CW]) sym = 0;
    end
    n_checks++;
    if (se != 524288 || so != 524288) begin
      n_fail++;
      $display("FAIL reset_bank_gain: got even=%0d odd=%0d, want 524288 each", se, so);
    end
    n_checks++;
    if (!sym) begin
      n_fail++;
      $display("FAIL reset_bank_symmetry: got asymmetric table, want linear phase");
    end
    @(negedge clk) rst_n = 1;
    model_clear();
  endtask

  task automatic test_coeff_write();
    int bad;
    longint se;
    for (int k = 0; k < NT; k++) nb[k] = k;
    drive(0, 16'h0, 0, 1);
    bad = 0;
    for (int k = 0; k < NT; k++) if (coeff_data_out[k*CW +: CW] !== CW'(k)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL coeff_readback: got %0d wrong taps (h[5]=%0d), want 0 (h[5]=5)", bad, coeff_data_out[5*CW +: CW]);
    end
    drive(0, 16'h0, 0, 0);
    #2 rst_n = 0;
    #1;
    se = 0;
    for (int k = 0; k < NT; k += 2) se += longint'($signed(coeff_data_out[k*CW +: CW]));
    n_checks++;
    if (se != 524288 || coeff_data_out[5*CW +: CW] === CW'(5)) begin
      n_fail++;
      $display("FAIL coeff_reset_restore: got even sum %0d h[5]=%0d, want 524288 and default table", se, coeff_data_out[5*CW +: CW]);
    end
    @(negedge clk) rst_n = 1;
    model_clear();
  endtask

  task automatic test_impulse();
    for (int k = 0; k < NT; k++) nb[k] = longint'(k + 1) << 10;
    drive(0, 16'h0, 0, 1);
    for (int n = 0; n < 80; n++) begin
      drive(1, n == 0 ? 16'h4000 : 16'h0000, 0, 0);
      n_checks++;
      if (valid_out !== exp_v || filter_out !== exp_y || overflow !== exp_o || underflow !== exp_u) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got v=%b y=%h o=%b u=%b, want v=%b y=%h o=%b u=%b",
                 n, valid_out, filter_out, overflow, underflow, exp_v, exp_y, exp_o, exp_u);
      end
    end
  endtask

  task automatic test_random();
    logic v, b, wr;
    for (int n = 0; n < 500; n++) begin
      v = $urandom_range(0, 9) < 7;
      b = $urandom_range(0, 19) == 0;
      wr = $urandom_range(0, 49) == 0;
      if (wr) rand_bank($urandom_range(14, 20));
      drive(v, 16'($urandom), b, wr);
      n_checks++;
      if (valid_out !== exp_v || filter_out !== exp_y || overflow !== exp_o || underflow !== exp_u) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b y=%h o=%b u=%b, want v=%b y=%h o=%b u=%b",
                 n, valid_out, filter_out, overflow, underflow, exp_v, exp_y, exp_o, exp_u);
      end
    end
  endtask

  task automatic test_saturation();
    logic ovf_seen, unf_seen;
    ovf_seen = 0;
    unf_seen = 0;
    for (int k = 0; k < NT; k++) nb[k] = 262143;
    drive(0, 16'h0, 1, 1);
    for (int n = 0; n < 80; n++) begin
      drive(1, n < 40 ? 16'h7fff : 16'h8000, 0, 0);
      if (overflow) ovf_seen = 1;
      if (underflow) unf_seen = 1;
      n_checks++;
      if (valid_out !== exp_v || filter_out !== exp_y || overflow !== exp_o || underflow !== exp_u) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got v=%b y=%h o=%b u=%b, want v=%b y=%h o=%b u=%b",
                 n, valid_out, filter_out, overflow, underflow, exp_v, exp_y, exp_o, exp_u);
      end
    end
    n_checks++;
    if (!ovf_seen || !unf_seen || filter_out !== 16'h8000) begin
      n_fail++;
      $display("FAIL saturation_flags: got ovf_seen=%b unf_seen=%b y=%h, want 1 1 8000", ovf_seen, unf_seen, filter_out);
    end
  endtask

  task automatic test_bypass();
    for (int n = 0; n < 106; n++) begin
      drive(1, n < 100 ? 16'(n) : 16'($urandom), n < 100, 0);
      n_checks++;
      if (valid_out !== exp_v || filter_out !== exp_y || overflow !== exp_o || underflow !== exp_u ||
          (n < 100 && (filter_out !== 16'(n) || valid_out !== 1'b1 || overflow || underflow))) begin
        n_fail++;
        $display("FAIL bypass[%0d]: got v=%b y=%h o=%b u=%b, want v=%b y=%h o=%b u=%b",
                 n, valid_out, filter_out, overflow, underflow, exp_v, exp_y, exp_o, exp_u);
      end
    end
  endtask

  task automatic test_gaps();
    int outs;
    outs = 0;
    rand_bank(16);
    drive(0, 16'h0, 1, 1);
    for (int n = 0; n < 90; n++) begin
      drive(n % 2 == 0, 16'($urandom), 0, 0);
      if (valid_out) outs++;
      n_checks++;
      if (valid_out !== exp_v || filter_out !== exp_y || overflow !== exp_o || underflow !== exp_u) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got v=%b y=%h o=%b u=%b, want v=%b y=%h o=%b u=%b",
                 n, valid_out, filter_out, overflow, underflow, exp_v, exp_y, exp_o, exp_u);
      end
    end
    n_checks++;
    if (outs != 30) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d outputs, want 30", outs);
    end
  endtask

  task automatic test_reset_midstream();
    longint se;
    rand_bank(18);
    drive(0, 16'h0, 0, 1);
    for (int n = 0; n < 10; n++) drive(1, 16'($urandom), 0, 0);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({valid_out, overflow, underflow} !== 3'b000 || filter_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_async: got v=%b o=%b u=%b y=%h, want 0 0 0 0000", valid_out, overflow, underflow, filter_out);
    end
    @(posedge clk);
    #1;
    se = 0;
    for (int k = 1; k < NT; k += 2) se += longint'($signed(coeff_data_out[k*CW +: CW]));
    n_checks++;
    if ({valid_out, overflow, underflow} !== 3'b000 || filter_out !== 16'h0000 || se != 524288) begin
      n_fail++;
      $display("FAIL midreset_next: got v=%b y=%h odd sum %0d, want 0 0000 524288", valid_out, filter_out, se);
    end
    @(negedge clk) rst_n = 1;
    model_clear();
  endtask

  task automatic test_dc();
    int outs;
    outs = 0;
    for (int n = 0; n < 48000; n++) begin
      drive(1, 16'h2000, 0, 0);
      if (valid_out) outs++;
    end
    n_checks++;
    if (outs != 32000) begin
      n_fail++;
      $display("FAIL dc_count: got %0d outputs, want 32000", outs);
    end
    n_checks++;
    if (filter_out < 16'h3fff || filter_out > 16'h4001) begin
      n_fail++;
      $display("FAIL dc_level: got %h, want 4000 +/-1", filter_out);
    end
  endtask

  initial begin
    test_reset();
    test_coeff_write();
    test_impulse();
    test_random();
    test_saturation();
    test_bypass();
    test_gaps();
    test_reset_midstream();
    test_dc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
